ysyx_22051013_icache: RTL and testbench
=======================================

# ysyx_22051013_icache

Direct-mapped instruction cache between the IF stage and the AXI master arbitrator's instruction port. Serves 32-bit instruction fetches combinationally on a hit. On a miss, refills a 16-byte line as two sequential 64-bit requests over the arbitrator's `icache_pc`/`icache_ena` → `axi_inst`/`axi_inst_valid` interface. Supports whole-cache invalidation for `fence.i`.

## Interface
- `INDEX_W`, default 6: index width; the cache has 2^INDEX_W lines of 16 bytes each.
- `clk  in  1`: clock.
- `rst  in  1`: reset. Asynchronous, active-low.
- `if_pc  in  64`: fetch address. Bits [1:0] are ignored.
- `if_req  in  1`: fetch request. IF holds it, with `if_pc` stable, until `if_inst_valid`, or drops it on redirect.
- `if_inst  out  32`: fetched instruction. Zero when `if_inst_valid`=0.
- `if_inst_valid  out  1`: `if_inst` valid this cycle. Single-cycle pulse per accepted fetch.
- `fence_i  in  1`: single-cycle pulse that invalidates all lines.
- `icache_pc  out  64`: refill beat address to the arbitrator. 8-byte aligned.
- `icache_ena  out  1`: refill request level to the arbitrator.
- `axi_inst  in  64`: refill beat data.
- `axi_inst_valid  in  1`: refill beat valid. Single-cycle pulse.

## Operation
- Address split:
  - offset = `if_pc[3:0]`
  - index = `if_pc[3+INDEX_W:4]`
  - tag = `if_pc[63:4+INDEX_W]`
  - word select = `if_pc[3:2]`; word 0 = line bits [31:0], up to word 3 = bits [127:96].
- Storage: per-line valid bit, tag, and 128-bit data in flops. Only the valid bits are reset. Tag and data are undefined after reset.
- hit = `if_req` & valid[index] & (tag[index] == tag field).
- FSM has three states: IDLE, REFILL0, REFILL1.
  - IDLE:
    - On hit: `if_inst_valid`=1, `if_inst` = selected word, same cycle.
    - On `if_req` & !hit: latch `miss_addr` = {`if_pc[63:4]`, 4'b0} and go to REFILL0.
  - REFILL0:
    - `icache_ena`=1, `icache_pc`=`miss_addr`.
    - On `axi_inst_valid`: data[index][63:0] ← `axi_inst`, go to REFILL1.
  - REFILL1:
    - `icache_ena`=1, `icache_pc`=`miss_addr`+8.
    - On `axi_inst_valid`: data[index][127:64] ← `axi_inst`; tag/valid of the `miss_addr` line written; go to IDLE.
- `icache_ena` and `icache_pc` are decoded from registered state only. In IDLE: `icache_ena`=0, `icache_pc`=0.
- `if_inst_valid` is never asserted outside IDLE.
- A refill, once started, always completes and installs the line. The arbitrator cannot abort a read.
  - `if_req` dropping or `if_pc` changing mid-refill does not affect the refill; `miss_addr` is used.
  - After the refill, IDLE re-evaluates the current `if_req`/`if_pc`.
- `fence_i`:
  - In IDLE: all valid bits cleared at the next edge. A hit in that same cycle is still served.
  - In REFILL0/REFILL1: sets a `fence_pend` flag. When the refill completes, all valid bits are cleared, including the line just filled, and `fence_pend` is cleared.
- `axi_inst_valid` in IDLE is ignored; no storage is written.
- Reset (asserted at any time, including mid-refill):
  - state → IDLE, all valid bits → 0, `fence_pend` → 0, `miss_addr` → 0.
  - Outputs `if_inst`=0, `if_inst_valid`=0, `icache_ena`=0, `icache_pc`=0.

## Timing
- Hit latency: 0 cycles. Valid in the same cycle as `if_req`.
- Miss, with the request presented at cycle t:
  - t+1: REFILL0 and `icache_ena` rise.
  - Beat 0 arrives at t+1+a; REFILL1 starts at the next edge.
  - Beat 1 arrives at t+2+a+b; IDLE at the next edge.
  - Hit at t+3+a+b.
  - Minimum miss penalty is 3 cycles, with a=b=0.
- `icache_ena` is a level held from REFILL0 entry until the final beat's edge, including the cycle of the final `axi_inst_valid`. It is low on the first IDLE cycle afterward, so the arbitrator sees no spurious third request.
- Between beats `icache_ena` stays high and `icache_pc` changes at the REFILL0→REFILL1 edge. The arbitrator samples a new request only when its read path is idle, so the second beat is accepted on or after that edge.
- Back-to-back misses to different lines: at least one IDLE cycle between refills, with `icache_ena`=0.

## Test plan
- Reset, then `if_req`=1, `if_pc`=0x8000_0000, and the stub answers each beat 2 cycles after `icache_ena`:
  - Required requests: `icache_pc`=0x8000_0000 then 0x8000_0008.
  - Beats 0x11111111_00000013 and 0x33333333_22222222.
  - Then `if_inst_valid` with `if_inst`=0x00000013.
- Following that refill, `if_pc`=0x8000_0004 / 0x8000_0008 / 0x8000_000C:
  - Required `if_inst` 0x11111111 / 0x22222222 / 0x33333333 on consecutive cycles.
  - `icache_ena` stays 0.
- Conflict: fetch 0x8000_0000, then 0x8000_0400 (same index with `INDEX_W`=6, different tag), then 0x8000_0000:
  - Required: three full refills.
  - `icache_ena` is low for at least one cycle between each.
- `fence_i` pulse in REFILL1, then fetch the same address:
  - The refill completes.
  - The next fetch misses again and issues a new refill at 0x8000_0000.
- `if_req` dropped and `if_pc` changed to 0x8000_1000 during REFILL0:
  - Both beats still use 0x8000_0000/0x8000_0008.
  - No `if_inst_valid` during the refill.
  - Then a new miss at 0x8000_1000.
- `rst` asserted low mid-REFILL1:
  - `icache_ena`, `if_inst_valid`, and `icache_pc` go to 0 immediately.
  - After release, a fetch to 0x8000_0000 misses.

Source files
------------

// File: rtl/ysyx_22051013_icache.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051013_icache
// Brief    : Direct-mapped instruction cache with 16-byte lines, refilled as
//            two 64-bit beats through the arbitrator's instruction port.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22051013_icache #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] if_pc,
    input  logic        if_req,
    output logic [31:0] if_inst,
    output logic        if_inst_valid,
    input  logic        fence_i,
    output logic [63:0] icache_pc,
    output logic        icache_ena,
    input  logic [63:0] axi_inst,
    input  logic        axi_inst_valid
);

    localparam int c_LINES = 1 << INDEX_W;
    localparam int c_TAG_W = 60 - INDEX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL0 = 2'd1;
    localparam logic [1:0] S_REFILL1 = 2'd2;

    logic [1:0]         r_state;
    logic [c_LINES-1:0] r_valid;
    logic               r_fence_pend;
    logic [63:0]        r_miss_addr;
    logic [c_TAG_W-1:0] r_tag  [c_LINES];
    logic [127:0]       r_data [c_LINES];

    logic [INDEX_W-1:0] w_index;
    logic [INDEX_W-1:0] w_fill_index;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_hit;
    logic [31:0]        w_word;
    logic [1:0]         w_unused_pc_lsb;

    assign w_index         = if_pc[3+INDEX_W:4];
    assign w_tag           = if_pc[63:4+INDEX_W];
    assign w_fill_index    = r_miss_addr[3+INDEX_W:4];
    assign w_unused_pc_lsb = if_pc[1:0];

    assign w_hit  = if_req && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_word = r_data[w_index][{if_pc[3:2], 5'b0} +: 32];

    assign if_inst_valid = (r_state == S_IDLE) && w_hit;
    assign if_inst       = if_inst_valid ? w_word : 32'd0;

    // Refill request decoded purely from registered state so it drops on the
    // very edge that completes the final beat.
    always_comb begin
        icache_ena = 1'b0;
        icache_pc  = 64'd0;
        case (r_state)
            S_REFILL0: begin
                icache_ena = 1'b1;
                icache_pc  = r_miss_addr;
            end
            S_REFILL1: begin
                icache_ena = 1'b1;
                icache_pc  = {r_miss_addr[63:4], 4'h8};
            end
            default: begin
                icache_ena = 1'b0;
                icache_pc  = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_fence_pend <= 1'b0;
            r_miss_addr  <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fence_i) begin
                        r_valid <= '0;
                    end
                    if (if_req && !w_hit) begin
                        r_miss_addr <= {if_pc[63:4], 4'b0};
                        r_state     <= S_REFILL0;
                    end
                end
                S_REFILL0: begin
                    if (fence_i) begin
                        r_fence_pend <= 1'b1;
                    end
                    if (axi_inst_valid) begin
                        r_state <= S_REFILL1;
                    end
                end
                S_REFILL1: begin
                    if (fence_i) begin
                        r_fence_pend <= 1'b1;
                    end
                    if (axi_inst_valid) begin
                        // A fence seen during the refill also kills the new line.
                        if (r_fence_pend || fence_i) begin
                            r_valid <= '0;
                        end else begin
                            r_valid[w_fill_index] <= 1'b1;
                        end
                        r_fence_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_REFILL0 && axi_inst_valid) begin
            r_data[w_fill_index][63:0] <= axi_inst;
        end
        if (r_state == S_REFILL1 && axi_inst_valid) begin
            r_data[w_fill_index][127:64] <= axi_inst;
            r_tag[w_fill_index]          <= r_miss_addr[63:4+INDEX_W];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22051013_icache
// Brief    : Directed self-checking bench with an AXI beat stub and a
//            scoreboard of expected refill addresses and instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] if_pc;
    logic        if_req;
    logic [31:0] if_inst;
    logic        if_inst_valid;
    logic        fence_i;
    logic [63:0] icache_pc;
    logic        icache_ena;
    logic [63:0] axi_inst;
    logic        axi_inst_valid;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    localparam logic [63:0] c_A0 = 64'h11111111_00000013;
    localparam logic [63:0] c_A1 = 64'h33333333_22222222;
    localparam logic [63:0] c_B0 = 64'hBBBBBBBB_AAAAAAAA;
    localparam logic [63:0] c_B1 = 64'hDDDDDDDD_CCCCCCCC;
    localparam logic [63:0] c_C0 = 64'h0C0C0C0C_05050505;
    localparam logic [63:0] c_C1 = 64'h0E0E0E0E_0D0D0D0D;

    ysyx_22051013_icache #(.INDEX_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_req         (if_req),
        .if_inst        (if_inst),
        .if_inst_valid  (if_inst_valid),
        .fence_i        (fence_i),
        .icache_pc      (icache_pc),
        .icache_ena     (icache_ena),
        .axi_inst       (axi_inst),
        .axi_inst_valid (axi_inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [63:0] b0, input logic [63:0] b1,
                                         input logic [63:0] pc);
        logic [127:0] line;
        line = {b1, b0};
        return line[{pc[3:2], 5'b0} +: 32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag);
        logic [63:0] e;
        e = (exp_pc_q.size() != 0) ? exp_pc_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        chk(tag, icache_pc, e);
    endtask

    task automatic chk_inst(input string tag);
        logic [31:0] e;
        e = (exp_inst_q.size() != 0) ? exp_inst_q.pop_front() : 32'hDEAD_BEEF;
        chk(tag, {32'd0, if_inst}, {32'd0, e});
    endtask

    task automatic expect_refill(input logic [63:0] pc);
        exp_pc_q.push_back({pc[63:4], 4'h0});
        exp_pc_q.push_back({pc[63:4], 4'h8});
    endtask

    // Stub arbitrator: answers each beat dly cycles after the request is seen.
    task automatic do_refill(input int dly, input logic [63:0] b0, input logic [63:0] b1,
                             input bit fence_r1, input bit redirect, input logic [63:0] redir_pc);
        int n;
        n = 0;
        while (!icache_ena && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ena_rise", {63'd0, icache_ena}, 64'd1);
        chk_pc("beat0_addr");
        if (redirect) begin
            if_req = 1'b0;
            if_pc  = redir_pc;
        end
        for (int i = 0; i < dly; i++) begin
            chk("r0_no_valid", {63'd0, if_inst_valid}, 64'd0);
            chk("r0_ena", {63'd0, icache_ena}, 64'd1);
            @(negedge clk);
        end
        axi_inst       = b0;
        axi_inst_valid = 1'b1;
        @(negedge clk);
        axi_inst_valid = 1'b0;
        chk("r1_ena", {63'd0, icache_ena}, 64'd1);
        chk_pc("beat1_addr");
        for (int i = 0; i < dly; i++) begin
            fence_i = fence_r1 && (i == 0);
            chk("r1_no_valid", {63'd0, if_inst_valid}, 64'd0);
            @(negedge clk);
            fence_i = 1'b0;
        end
        axi_inst       = b1;
        axi_inst_valid = 1'b1;
        #1;
        chk("final_beat_ena", {63'd0, icache_ena}, 64'd1);
        @(negedge clk);
        axi_inst_valid = 1'b0;
        chk("ena_drop", {63'd0, icache_ena}, 64'd0);
        chk("pc_drop", icache_pc, 64'd0);
    endtask

    task automatic fetch_miss(input logic [63:0] pc, input logic [63:0] b0,
                              input logic [63:0] b1, input int dly);
        if_pc  = pc;
        if_req = 1'b1;
        expect_refill(pc);
        exp_inst_q.push_back(pick(b0, b1, pc));
        #1;
        chk("miss_no_valid", {63'd0, if_inst_valid}, 64'd0);
        do_refill(dly, b0, b1, 1'b0, 1'b0, 64'd0);
        chk("post_refill_valid", {63'd0, if_inst_valid}, 64'd1);
        chk_inst("post_refill_inst");
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic fetch_hit(input logic [63:0] pc, input logic [31:0] exp);
        if_pc  = pc;
        if_req = 1'b1;
        exp_inst_q.push_back(exp);
        #1;
        chk("hit_valid", {63'd0, if_inst_valid}, 64'd1);
        chk_inst("hit_inst");
        chk("hit_no_ena", {63'd0, icache_ena}, 64'd0);
        @(negedge clk);
    endtask

    task automatic idle_fence();
        if_req  = 1'b0;
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        if_pc          = 64'd0;
        if_req         = 1'b0;
        fence_i        = 1'b0;
        axi_inst       = 64'd0;
        axi_inst_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ena", {63'd0, icache_ena}, 64'd0);
        chk("rst_pc", icache_pc, 64'd0);
        chk("rst_valid", {63'd0, if_inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, if_inst}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss, then the remaining words of the line hit back to back.
        fetch_miss(64'h8000_0000, c_A0, c_A1, 2);
        fetch_hit(64'h8000_0004, 32'h11111111);
        fetch_hit(64'h8000_0008, 32'h22222222);
        fetch_hit(64'h8000_000C, 32'h33333333);
        if_req = 1'b0;
        @(negedge clk);

        // Fence in IDLE: the same-cycle hit is still served, then the line is gone.
        if_pc   = 64'h8000_0000;
        if_req  = 1'b1;
        fence_i = 1'b1;
        exp_inst_q.push_back(32'h00000013);
        #1;
        chk("fence_idle_hit", {63'd0, if_inst_valid}, 64'd1);
        chk_inst("fence_idle_inst");
        @(negedge clk);
        fence_i = 1'b0;
        if_req  = 1'b0;
        @(negedge clk);

        // Conflict misses on index 0.
        fetch_miss(64'h8000_0000, c_A0, c_A1, 1);
        fetch_miss(64'h8000_0400, c_B0, c_B1, 0);
        fetch_miss(64'h8000_0000, c_A0, c_A1, 1);

        // Fence during REFILL1: refill completes but the fetch misses again.
        idle_fence();
        if_pc  = 64'h8000_0000;
        if_req = 1'b1;
        expect_refill(64'h8000_0000);
        do_refill(2, c_A0, c_A1, 1'b1, 1'b0, 64'd0);
        chk("fence_r1_no_hit", {63'd0, if_inst_valid}, 64'd0);
        expect_refill(64'h8000_0000);
        exp_inst_q.push_back(32'h00000013);
        do_refill(1, c_A0, c_A1, 1'b0, 1'b0, 64'd0);
        chk("refetch_valid", {63'd0, if_inst_valid}, 64'd1);
        chk_inst("refetch_inst");
        if_req = 1'b0;
        @(negedge clk);

        // Redirect during REFILL0: refill still uses the original address.
        idle_fence();
        if_pc  = 64'h8000_0000;
        if_req = 1'b1;
        expect_refill(64'h8000_0000);
        do_refill(2, c_A0, c_A1, 1'b0, 1'b1, 64'h8000_1000);
        chk("redir_no_valid", {63'd0, if_inst_valid}, 64'd0);
        fetch_hit(64'h8000_0008, 32'h22222222);
        if_req = 1'b0;
        @(negedge clk);
        fetch_miss(64'h8000_1000, c_C0, c_C1, 1);

        // Reset mid-REFILL1.
        if_pc  = 64'h8000_0000;
        if_req = 1'b1;
        @(negedge clk);
        chk("rr_ena", {63'd0, icache_ena}, 64'd1);
        chk("rr_pc0", icache_pc, 64'h8000_0000);
        axi_inst       = c_A0;
        axi_inst_valid = 1'b1;
        @(negedge clk);
        axi_inst_valid = 1'b0;
        chk("rr_pc1", icache_pc, 64'h8000_0008);
        rst = 1'b0;
        #1;
        chk("rr_ena_low", {63'd0, icache_ena}, 64'd0);
        chk("rr_pc_low", icache_pc, 64'd0);
        chk("rr_valid_low", {63'd0, if_inst_valid}, 64'd0);
        chk("rr_inst_low", {32'd0, if_inst}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        fetch_miss(64'h8000_0000, c_A0, c_A1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
